mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory responder for the five-stage pipeline. It takes the memory request held in the EX/MEM pipeline register (MemRead/MemWrite, ALU result as address, store data), runs a req/ack handshake to the data memory, and holds `stall_o` high until the access completes. It returns load data to the MEM/WB register. `stall_o` feeds the stall inputs of the upstream pipeline registers, so the request stays stable for the whole access.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles in REQ waiting for `mem_ack_i` before the access is aborted.

Ports:
- `clk_i`  in  1  clock. One clock domain; all state changes on its rising edge.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `MemRead_i`  in  1  load request from EX/MEM.
- `MemWrite_i`  in  1  store request from EX/MEM.
- `addr_i`  in  32  byte address (EX/MEM ALU result).
- `wrdata_i`  in  32  store data.
- `rddata_o`  out  32  load data for MEM/WB. Valid in the DONE cycle; holds its value afterwards.
- `stall_o`  out  1  freeze request to the pipeline registers.
- `misalign_o`  out  1  one-cycle pulse: request with `addr_i[1:0]` not equal to 0.
- `timeout_o`  out  1  one-cycle pulse: access aborted by timeout.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  32  word-aligned address.
- `mem_wdata_o`  out  32  write data.
- `mem_ack_i`  in  1  memory completion.
- `mem_rdata_i`  in  32  read data. Valid only while `mem_ack_i` is high.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - A valid request is `MemRead_i` or `MemWrite_i` high with `addr_i[1:0]` equal to 0.
  - On a valid request: `stall_o` is driven high combinationally in that same cycle. Latch `addr_i`, `wrdata_i` and the write flag. Next state is REQ.
  - Misaligned request: pulse `misalign_o`. No memory access, no stall, `rddata_o` unchanged. Stay in IDLE.
  - `MemRead_i` and `MemWrite_i` both high: treated as a write.
  - `mem_ack_i` is ignored in IDLE and in DONE.
- **REQ**
  - Drive `mem_req_o`=1. `mem_we_o`, `mem_addr_o` and `mem_wdata_o` come from the latched values and stay stable until ack. `stall_o`=1.
  - On `mem_ack_i`: if the access is a read, capture `mem_rdata_i` into `rddata_o`. Next state is DONE.
  - Wait counter: reset to 0 on entry to REQ, increments each REQ cycle without ack.
  - Timeout: on the cycle the counter reaches TIMEOUT-1 without ack, pulse `timeout_o` on the next cycle, drop the request and go to DONE. `rddata_o` keeps its old value.
- **DONE**
  - `stall_o`=0 and `mem_req_o`=0. Next state is IDLE unconditionally.
  - The pipeline advances at the end of this cycle. The still-present old request is not reissued.
- `mem_req_o` is a registered state decode and never glitches.
- `mem_addr_o[1:0]` is always 0.

## Timing
- Reset values:
  - state IDLE
  - `rddata_o`=0
  - `stall_o`=0
  - `mem_req_o`=0, `mem_we_o`=0
  - `mem_addr_o`=0, `mem_wdata_o`=0
  - `misalign_o`=0, `timeout_o`=0
  - wait counter 0
- Stall length equals 1 + N cycles, where N ≥ 1 is the number of REQ cycles up to and including the ack cycle. With ack in the first REQ cycle, the stall lasts 2 cycles.
- Back-to-back memory instructions: the second request is seen in the IDLE cycle after DONE. There is no bubble beyond the stall.
- Reset mid-access: reset during REQ returns the FSM to IDLE on the next edge and drops `mem_req_o`. A later stray `mem_ack_i` is ignored.
- Ack and reset in the same cycle: reset wins and data is not captured.
- Timeout and ack in the same cycle: the ack wins and the access completes normally.

## Structure
- Shared package (`mem_pkg`):
  - state enum: IDLE=2'd0, REQ=2'd1, DONE=2'd2
  - word width constant (32)
- Counter width: `$clog2(TIMEOUT)`.
- Single module. No sub-module; the FSM, request latch and wait counter are small enough to keep inline.

## Test plan
- **Load, immediate ack:** MemRead=1, addr=0x100; memory acks in the first REQ cycle with rdata=0xDEADBEEF -> `stall_o` is high for exactly 2 cycles, `mem_we_o`=0, `mem_addr_o`=0x100, `rddata_o`=0xDEADBEEF in DONE.
- **Store, 3-cycle ack delay:** MemWrite=1, addr=0x204, wrdata=0x12345678; ack arrives on the 3rd REQ cycle -> `stall_o` is high for 4 cycles, `mem_wdata_o` is stable at 0x12345678 throughout, `rddata_o` is unchanged.
- **Misaligned load:** MemRead=1, addr=0x103 -> `misalign_o` pulses for 1 cycle, `mem_req_o` never rises, `stall_o` stays 0.
- **Timeout:** TIMEOUT=8, load with no ack -> `mem_req_o` is high for 8 cycles, then `timeout_o` pulses, `stall_o` falls, and the FSM is in IDLE 2 cycles later.
- **Reset mid-access:** assert `rst_i` in the 2nd REQ cycle, then ack 1 cycle after reset -> `mem_req_o`=0 and `stall_o`=0 after the reset edge; the ack is ignored and `rddata_o`=0.
- **Back-to-back:** a store followed immediately by a load to 0x300, each acked in 1 cycle -> two separate handshakes; the load's request starts the cycle after the store's DONE, and total stall is 4 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage data-memory responder.
//   state_e : FSM encoding for the access sequencer (IDLE, REQ, DONE)
//   WORD_W  : datapath width for addresses and data words
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory responder. Takes the load/store request sitting in
// the EX/MEM register, runs a req/ack handshake with data memory and freezes
// the pipeline until the access completes (or times out).
//
// Parameters:
//   TIMEOUT      max REQ cycles without ack before the access is aborted
// Ports:
//   clk_i        clock, all state changes on rising edge
//   rst_i        synchronous active-high reset
//   MemRead_i    load request from EX/MEM
//   MemWrite_i   store request from EX/MEM (wins if both are set)
//   addr_i       byte address (ALU result)
//   wrdata_i     store data
//   rddata_o     load data for MEM/WB, valid in DONE and held afterwards
//   stall_o      freeze request to upstream pipeline registers
//   misalign_o   one-cycle pulse after a misaligned request is seen
//   timeout_o    one-cycle pulse when an access is aborted by timeout
//   mem_req_o    memory request (registered)
//   mem_we_o     1 = write, 0 = read
//   mem_addr_o   word-aligned memory address
//   mem_wdata_o  memory write data
//   mem_ack_i    memory completion
//   mem_rdata_i  memory read data, valid while mem_ack_i is high
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wrdata_i,
  output logic [WORD_W-1:0] rddata_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              timeout_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [WORD_W-1:0] mem_rdata_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_waitCnt;
  logic [WORD_W-1:0] r_rddata;
  logic              r_misalign;
  logic              r_timeout;
  logic              r_memReq;
  logic              r_memWe;
  logic [WORD_W-1:0] r_memAddr;
  logic [WORD_W-1:0] r_memWdata;

  logic w_anyReq;
  logic w_aligned;
  logic w_validReq;

  // Classify whatever the EX/MEM register is presenting this cycle. Only an
  // aligned load or store starts a memory access; a misaligned one is only
  // flagged.
  assign w_anyReq   = MemRead_i | MemWrite_i;
  assign w_aligned  = (addr_i[1:0] == 2'b00);
  assign w_validReq = w_anyReq & w_aligned;

  // The stall must rise in the very IDLE cycle the request appears, otherwise
  // the upstream registers would advance past the instruction before the
  // access starts. It stays up through every REQ cycle and drops in DONE so
  // the pipeline moves on at the end of DONE.
  assign stall_o = (r_state == REQ) || ((r_state == IDLE) && w_validReq);

  assign rddata_o    = r_rddata;
  assign misalign_o  = r_misalign;
  assign timeout_o   = r_timeout;
  assign mem_req_o   = r_memReq;
  assign mem_we_o    = r_memWe;
  assign mem_addr_o  = r_memAddr;
  assign mem_wdata_o = r_memWdata;

  // Access sequencer. The request fields are latched on entry to REQ so the
  // memory sees stable values for the whole handshake. mem_req_o is its own
  // flop updated alongside the state so it is glitch-free. In DONE the old
  // request is still on the inputs but is deliberately not looked at, so it
  // is never reissued. An ack arriving on the final wait cycle still counts
  // as a normal completion because it is checked before the timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_waitCnt  <= '0;
      r_rddata   <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else begin
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_validReq) begin
            r_state    <= REQ;
            r_memReq   <= 1'b1;
            r_memWe    <= MemWrite_i;
            r_memAddr  <= {addr_i[WORD_W-1:2], 2'b00};
            r_memWdata <= wrdata_i;
            r_waitCnt  <= '0;
          end else if (w_anyReq) begin
            r_misalign <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            if (!r_memWe) begin
              r_rddata <= mem_rdata_i;
            end
            r_state  <= DONE;
            r_memReq <= 1'b0;
          end else if (r_waitCnt == LAST_WAIT) begin
            r_timeout <= 1'b1;
            r_state   <= DONE;
            r_memReq  <= 1'b0;
          end else begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit (TIMEOUT = 8). Each cycle the bench
// drives the EX/MEM request and the memory response, then compares outputs
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk_i;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wrdata_i;
  logic [31:0] rddata_o;
  logic        stall_o;
  logic        misalign_o;
  logic        timeout_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int compareCount;
  int mismatchCount;
  int stallCycles;

  mem_access_unit #(
    .TIMEOUT(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .wrdata_i   (wrdata_i),
    .rddata_o   (rddata_o),
    .stall_o    (stall_o),
    .misalign_o (misalign_o),
    .timeout_o  (timeout_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  // Free-running 10 ns clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one clock and step just past the edge so registered outputs
  // have settled.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive the request and memory-response inputs for the current cycle and
  // let the combinational stall settle before anything is sampled.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic ack, input logic [31:0] rdata);
    MemRead_i   = rd;
    MemWrite_i  = wr;
    addr_i      = addr;
    wrdata_i    = wdata;
    mem_ack_i   = ack;
    mem_rdata_i = rdata;
    #1;
  endtask

  // Single comparison point: counts and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    stallCycles   = 0;
    rst_i         = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst_i = 1'b0;

    // Reset state
    checkOutput("rst_rddata", rddata_o, 32'h0);
    checkOutput("rst_stall", {31'b0, stall_o}, 32'h0);
    checkOutput("rst_req", {31'b0, mem_req_o}, 32'h0);
    checkOutput("rst_we", {31'b0, mem_we_o}, 32'h0);
    checkOutput("rst_addr", mem_addr_o, 32'h0);
    checkOutput("rst_wdata", mem_wdata_o, 32'h0);
    checkOutput("rst_misalign", {31'b0, misalign_o}, 32'h0);
    checkOutput("rst_timeout", {31'b0, timeout_o}, 32'h0);

    // Load with immediate ack: stall for IDLE + one REQ cycle
    $display("[TB] load, immediate ack");
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    checkOutput("ld_idle_stall", {31'b0, stall_o}, 32'h1);
    checkOutput("ld_idle_req", {31'b0, mem_req_o}, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
    checkOutput("ld_req", {31'b0, mem_req_o}, 32'h1);
    checkOutput("ld_we", {31'b0, mem_we_o}, 32'h0);
    checkOutput("ld_addr", mem_addr_o, 32'h100);
    checkOutput("ld_req_stall", {31'b0, stall_o}, 32'h1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    checkOutput("ld_done_stall", {31'b0, stall_o}, 32'h0);
    checkOutput("ld_done_req", {31'b0, mem_req_o}, 32'h0);
    checkOutput("ld_done_rddata", rddata_o, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("ld_after_stall", {31'b0, stall_o}, 32'h0);
    checkOutput("ld_after_req", {31'b0, mem_req_o}, 32'h0);

    // Store, ack on third REQ cycle; read data on the bus must be ignored
    $display("[TB] store, 3-cycle ack");
    applyStimulus(1'b0, 1'b1, 32'h204, 32'h12345678, 1'b0, 32'h0);
    checkOutput("st_idle_stall", {31'b0, stall_o}, 32'h1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      applyStimulus(1'b0, 1'b1, 32'h204, 32'h12345678, (c == 3), 32'hCAFEF00D);
      checkOutput("st_req", {31'b0, mem_req_o}, 32'h1);
      checkOutput("st_we", {31'b0, mem_we_o}, 32'h1);
      checkOutput("st_addr", mem_addr_o, 32'h204);
      checkOutput("st_wdata", mem_wdata_o, 32'h12345678);
      checkOutput("st_stall", {31'b0, stall_o}, 32'h1);
    end
    tick();
    applyStimulus(1'b0, 1'b1, 32'h204, 32'h12345678, 1'b0, 32'h0);
    checkOutput("st_done_stall", {31'b0, stall_o}, 32'h0);
    checkOutput("st_done_req", {31'b0, mem_req_o}, 32'h0);
    checkOutput("st_done_rddata", rddata_o, 32'hDEADBEEF);
    tick();

    // Misaligned load: registered one-cycle pulse, no access, no stall
    $display("[TB] misaligned load");
    applyStimulus(1'b1, 1'b0, 32'h103, 32'h0, 1'b0, 32'h0);
    checkOutput("mis_stall", {31'b0, stall_o}, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("mis_pulse", {31'b0, misalign_o}, 32'h1);
    checkOutput("mis_req", {31'b0, mem_req_o}, 32'h0);
    checkOutput("mis_stall2", {31'b0, stall_o}, 32'h0);
    tick();
    checkOutput("mis_pulse_end", {31'b0, misalign_o}, 32'h0);
    checkOutput("mis_req2", {31'b0, mem_req_o}, 32'h0);
    checkOutput("mis_rddata", rddata_o, 32'hDEADBEEF);

    // Timeout: 8 REQ cycles with no ack, then DONE with timeout pulse
    $display("[TB] timeout");
    applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
    checkOutput("to_idle_stall", {31'b0, stall_o}, 32'h1);
    for (int c = 0; c < 8; c++) begin
      tick();
      applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
      checkOutput("to_req", {31'b0, mem_req_o}, 32'h1);
      checkOutput("to_no_pulse", {31'b0, timeout_o}, 32'h0);
    end
    tick();
    applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
    checkOutput("to_pulse", {31'b0, timeout_o}, 32'h1);
    checkOutput("to_done_req", {31'b0, mem_req_o}, 32'h0);
    checkOutput("to_done_stall", {31'b0, stall_o}, 32'h0);
    checkOutput("to_rddata", rddata_o, 32'hDEADBEEF);
    tick();

    // Back in IDLE: a fresh load raises stall at once. This is also the
    // start of the reset-mid-access case.
    $display("[TB] reset mid-access");
    applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0);
    checkOutput("to_back_idle", {31'b0, stall_o}, 32'h1);
    checkOutput("to_pulse_end", {31'b0, timeout_o}, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0);
    checkOutput("rm_req1", {31'b0, mem_req_o}, 32'h1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h55555555);
    checkOutput("rm_req", {31'b0, mem_req_o}, 32'h0);
    checkOutput("rm_stall", {31'b0, stall_o}, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("rm_rddata", rddata_o, 32'h0);
    checkOutput("rm_req_after", {31'b0, mem_req_o}, 32'h0);

    // Back-to-back store then load, each acked at once: 4 stall cycles total
    $display("[TB] back-to-back");
    applyStimulus(1'b0, 1'b1, 32'h600, 32'hA5A5A5A5, 1'b0, 32'h0);
    stallCycles += stall_o;
    tick();
    applyStimulus(1'b0, 1'b1, 32'h600, 32'hA5A5A5A5, 1'b1, 32'h0);
    stallCycles += stall_o;
    checkOutput("bb_st_we", {31'b0, mem_we_o}, 32'h1);
    checkOutput("bb_st_addr", mem_addr_o, 32'h600);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h600, 32'hA5A5A5A5, 1'b0, 32'h0);
    stallCycles += stall_o;
    checkOutput("bb_st_done_req", {31'b0, mem_req_o}, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    stallCycles += stall_o;
    tick();
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'h0BADF00D);
    stallCycles += stall_o;
    checkOutput("bb_ld_req", {31'b0, mem_req_o}, 32'h1);
    checkOutput("bb_ld_we", {31'b0, mem_we_o}, 32'h0);
    checkOutput("bb_ld_addr", mem_addr_o, 32'h300);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    stallCycles += stall_o;
    checkOutput("bb_ld_rddata", rddata_o, 32'h0BADF00D);
    checkOutput("bb_stall_total", stallCycles, 32'd4);
    tick();

    // Ack arriving on the last allowed wait cycle beats the timeout
    $display("[TB] ack on last wait cycle");
    applyStimulus(1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      tick();
      applyStimulus(1'b1, 1'b0, 32'h700, 32'h0, (c == 7), 32'h13579BDF);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("late_ack_timeout", {31'b0, timeout_o}, 32'h0);
    checkOutput("late_ack_rddata", rddata_o, 32'h13579BDF);
    checkOutput("late_ack_req", {31'b0, mem_req_o}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
